// File: rtl/sram_arbiter.sv
// Multi-channel arbiter and strobe timing generator for a single-port asynchronous SRAM.
// Access sequence per grant: IDLE -> SETUP -> ACTIVE (WAIT_CYCLES) -> HOLD -> IDLE.
module sram_arbiter #(
  parameter int NCH         = 2,
  parameter int AW          = 19,
  parameter int DW          = 8,
  parameter int WAIT_CYCLES = 2,
  parameter int RR          = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NCH-1:0]    req,
  input  logic [NCH-1:0]    we,
  input  logic [NCH*AW-1:0] addr,
  input  logic [NCH*DW-1:0] din,
  output logic [NCH-1:0]    ack,
  output logic [DW-1:0]     dout,
  output logic              busy,
  output logic [AW-1:0]     sram_addr,
  output logic [DW-1:0]     sram_dout,
  output logic              sram_oe,
  input  logic [DW-1:0]     sram_din,
  output logic              sram_we_n
);

  localparam int GW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, SETUP, ACTIVE, HOLD} state_t;

  state_t          state_q, state_d;
  logic [GW-1:0]   gnt_q, gnt_d;
  logic [GW-1:0]   last_q, last_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic            oe_q, oe_d;
  logic            we_n_q, we_n_d;
  logic [NCH-1:0]  ack_q, ack_d;
  logic [DW-1:0]   dout_q, dout_d;

  logic            sel_vld;
  logic [GW-1:0]   sel_idx;

  // Descending scans so the last hit (highest priority) wins.
  always_comb begin
    sel_vld = |req;
    sel_idx = '0;
    if (RR != 0 && NCH > 1) begin
      for (int k = NCH; k >= 1; k--) begin
        if (req[(int'(last_q) + k) % NCH]) sel_idx = GW'((int'(last_q) + k) % NCH);
      end
    end else begin
      for (int i = NCH - 1; i >= 0; i--) begin
        if (req[i]) sel_idx = GW'(i);
      end
    end
  end

  // oe_q doubles as the latched write flag for the whole access.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    oe_d    = oe_q;
    we_n_d  = 1'b1;
    ack_d   = '0;
    dout_d  = dout_q;
    case (state_q)
      IDLE: begin
        if (sel_vld) begin
          state_d = SETUP;
          gnt_d   = sel_idx;
          last_d  = sel_idx;
          addr_d  = addr[sel_idx*AW +: AW];
          wdata_d = din[sel_idx*DW +: DW];
          oe_d    = we[sel_idx];
        end
      end
      SETUP: begin
        state_d = ACTIVE;
        cnt_d   = CW'(WAIT_CYCLES - 1);
        we_n_d  = ~oe_q;
      end
      ACTIVE: begin
        if (cnt_q == '0) begin
          state_d      = HOLD;
          ack_d[gnt_q] = 1'b1;
          if (!oe_q) dout_d = sram_din;
        end else begin
          cnt_d  = cnt_q - CW'(1);
          we_n_d = ~oe_q;
        end
      end
      HOLD: begin
        state_d = IDLE;
        oe_d    = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      last_q  <= GW'(NCH - 1);
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      oe_q    <= 1'b0;
      we_n_q  <= 1'b1;
      ack_q   <= '0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      oe_q    <= oe_d;
      we_n_q  <= we_n_d;
      ack_q   <= ack_d;
      dout_q  <= dout_d;
    end
  end

  assign ack       = ack_q;
  assign dout      = dout_q;
  assign busy      = (state_q != IDLE);
  assign sram_addr = addr_q;
  assign sram_dout = wdata_q;
  assign sram_oe   = oe_q;
  assign sram_we_n = we_n_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: a fixed-priority and a round-robin instance (NCH=3, WAIT_CYCLES=2),
// each with its own SRAM pin model, compared every cycle against a transaction-level model.
module tb_sram_arbiter;
  localparam int NCH = 3;
  localparam int AW  = 19;
  localparam int DW  = 8;
  localparam int WC  = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [NCH-1:0]    req_s [2];
  logic [NCH-1:0]    we_s [2];
  logic [NCH*AW-1:0] addr_s [2];
  logic [NCH*DW-1:0] din_s [2];
  logic [NCH-1:0]    ack_s [2];
  logic [DW-1:0]     dout_s [2];
  logic              busy_s [2];
  logic [AW-1:0]     sram_addr_s [2];
  logic [DW-1:0]     sram_dout_s [2];
  logic              oe_s [2];
  logic [DW-1:0]     sram_din_s [2];
  logic              we_n_s [2];

  logic [NCH-1:0]    keep [2];
  bit                rand_en = 1'b0;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [7:0] pmem [int];
  logic [7:0] rmem [int];
  bit         pend [2];
  logic [AW-1:0] pa [2];
  logic [DW-1:0] pd [2];

  // Transaction-level model state
  bit            m_act [2];
  int            m_t0 [2];
  int            m_g [2];
  bit            m_we [2];
  logic [AW-1:0] m_a [2];
  logic [DW-1:0] m_d [2];
  int            m_last [2];
  logic [AW-1:0] e_addr [2];
  logic [DW-1:0] e_sdout [2];
  logic [DW-1:0] e_dout [2];

  int ackq0 [$];
  int ackq1 [$];
  int ackc0 [$];

  logic [AW-1:0] pool [6] = '{19'h00100, 19'h12345, 19'h00000, 19'h7FFFF, 19'h2AAAA, 19'h00101};

  sram_arbiter #(.NCH(NCH), .AW(AW), .DW(DW), .WAIT_CYCLES(WC), .RR(0)) u_fix (
    .clk(clk), .rst(rst), .req(req_s[0]), .we(we_s[0]), .addr(addr_s[0]), .din(din_s[0]),
    .ack(ack_s[0]), .dout(dout_s[0]), .busy(busy_s[0]), .sram_addr(sram_addr_s[0]),
    .sram_dout(sram_dout_s[0]), .sram_oe(oe_s[0]), .sram_din(sram_din_s[0]),
    .sram_we_n(we_n_s[0]));

  sram_arbiter #(.NCH(NCH), .AW(AW), .DW(DW), .WAIT_CYCLES(WC), .RR(1)) u_rr (
    .clk(clk), .rst(rst), .req(req_s[1]), .we(we_s[1]), .addr(addr_s[1]), .din(din_s[1]),
    .ack(ack_s[1]), .dout(dout_s[1]), .busy(busy_s[1]), .sram_addr(sram_addr_s[1]),
    .sram_dout(sram_dout_s[1]), .sram_oe(oe_s[1]), .sram_din(sram_din_s[1]),
    .sram_we_n(we_n_s[1]));

  always #5 clk = ~clk;

  function automatic int key(int d, logic [AW-1:0] a);
    return (d << AW) | int'(a);
  endfunction

  function automatic logic [7:0] dflt(logic [AW-1:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  function automatic logic [7:0] prd(int d, logic [AW-1:0] a);
    if (pmem.exists(key(d, a))) return pmem[key(d, a)];
    return dflt(a);
  endfunction

  function automatic logic [7:0] rrd(int d, logic [AW-1:0] a);
    if (rmem.exists(key(d, a))) return rmem[key(d, a)];
    return dflt(a);
  endfunction

  // SRAM pin model: a write lands when we_n rises without reset; reset discards it.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        pend[d] = 1'b0;
      end else if (!we_n_s[d]) begin
        pend[d] = 1'b1;
        pa[d]   = sram_addr_s[d];
        pd[d]   = sram_dout_s[d];
      end else if (pend[d]) begin
        pmem[key(d, pa[d])] = pd[d];
        pend[d] = 1'b0;
      end
      sram_din_s[d] = prd(d, sram_addr_s[d]);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic new_fields(input int d, input int ch);
    we_s[d][ch] = 1'($urandom_range(0, 1));
    addr_s[d][ch*AW +: AW] = pool[$urandom_range(0, 5)];
    din_s[d][ch*DW +: DW] = 8'($urandom);
  endtask

  // Advance the model to the cycle that begins at this clock edge.
  task automatic model_edge(input int d);
    int x;
    int g;
    x = cyc - 1;
    if (rst) begin
      m_act[d] = 1'b0; m_last[d] = NCH - 1;
      e_addr[d] = '0; e_sdout[d] = '0; e_dout[d] = '0;
    end else begin
      if ((!m_act[d] || x > m_t0[d] + WC + 2) && req_s[d] != '0) begin
        g = -1;
        if (d == 1) begin
          for (int k = 1; k <= NCH; k++) begin
            int i;
            i = (m_last[d] + k) % NCH;
            if (g < 0 && req_s[d][i]) g = i;
          end
        end else begin
          for (int i = 0; i < NCH; i++) if (g < 0 && req_s[d][i]) g = i;
        end
        m_act[d] = 1'b1; m_t0[d] = x; m_g[d] = g; m_last[d] = g;
        m_we[d] = we_s[d][g];
        m_a[d]  = addr_s[d][g*AW +: AW];
        m_d[d]  = din_s[d][g*DW +: DW];
        e_addr[d] = m_a[d]; e_sdout[d] = m_d[d];
      end
      if (m_act[d] && cyc == m_t0[d] + WC + 2) begin
        if (m_we[d]) rmem[key(d, m_a[d])] = m_d[d];
        else e_dout[d] = rrd(d, m_a[d]);
      end
    end
  endtask

  task automatic compare(input int d);
    bit inn;
    logic [NCH-1:0] e_ack;
    inn = m_act[d] && cyc >= m_t0[d] + 1 && cyc <= m_t0[d] + WC + 2;
    e_ack = (inn && cyc == m_t0[d] + WC + 2) ? NCH'(1 << m_g[d]) : '0;
    chk($sformatf("d%0d_busy", d), busy_s[d], inn);
    chk($sformatf("d%0d_ack", d), ack_s[d], e_ack);
    chk($sformatf("d%0d_oe", d), oe_s[d], inn && m_we[d]);
    chk($sformatf("d%0d_we_n", d), we_n_s[d],
        !(inn && m_we[d] && cyc >= m_t0[d] + 2 && cyc <= m_t0[d] + WC + 1));
    chk($sformatf("d%0d_sram_addr", d), sram_addr_s[d], e_addr[d]);
    chk($sformatf("d%0d_sram_dout", d), sram_dout_s[d], e_sdout[d]);
    chk($sformatf("d%0d_dout", d), dout_s[d], e_dout[d]);
  endtask

  task automatic drive(input int d);
    for (int ch = 0; ch < NCH; ch++) begin
      if (ack_s[d][ch]) begin
        if (rand_en && $urandom_range(0, 2) == 0) new_fields(d, ch);
        else if (rand_en || !keep[d][ch]) req_s[d][ch] = 1'b0;
      end else if (rand_en && !req_s[d][ch] && $urandom_range(0, 3) == 0) begin
        new_fields(d, ch);
        req_s[d][ch] = 1'b1;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    for (int d = 0; d < 2; d++) model_edge(d);
    #1;
    for (int d = 0; d < 2; d++) compare(d);
    for (int ch = 0; ch < NCH; ch++) begin
      if (ack_s[0][ch]) begin ackq0.push_back(ch); ackc0.push_back(cyc); end
      if (ack_s[1][ch]) ackq1.push_back(ch);
    end
    for (int d = 0; d < 2; d++) drive(d);
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      req_s[d] = 3'($urandom); we_s[d] = 3'($urandom);
      addr_s[d] = {pool[1], pool[3], pool[4]}; din_s[d] = 24'($urandom);
      keep[d] = '0; sram_din_s[d] = '0; pend[d] = 1'b0;
    end

    // Reset held with random inputs
    for (int r = 0; r < 3; r++) begin
      step();
      for (int d = 0; d < 2; d++) req_s[d] = 3'($urandom);
    end
    for (int d = 0; d < 2; d++) begin
      chk("rst_we_n", we_n_s[d], 1'b1);
      chk("rst_oe", oe_s[d], 1'b0);
      chk("rst_ack", ack_s[d], 3'b000);
      chk("rst_busy", busy_s[d], 1'b0);
      req_s[d] = '0; we_s[d] = '0;
    end
    rst = 1'b0;
    step();

    // Single read by channel 1
    for (int d = 0; d < 2; d++) begin
      addr_s[d][1*AW +: AW] = 19'h12345;
      pmem[key(d, 19'h12345)] = 8'hA5;
      rmem[key(d, 19'h12345)] = 8'hA5;
      req_s[d][1] = 1'b1;
    end
    for (int r = 1; r <= 6; r++) begin
      step();
      for (int d = 0; d < 2; d++) begin
        if (r <= 4) chk("rd_addr", sram_addr_s[d], 19'h12345);
        chk("rd_we_n", we_n_s[d], 1'b1);
        if (r == 4) chk("rd_ack", ack_s[d], 3'b010);
        if (r >= 4) chk("rd_dout", dout_s[d], 8'hA5);
      end
    end

    // Single write by channel 0
    for (int d = 0; d < 2; d++) begin
      we_s[d][0] = 1'b1;
      addr_s[d][0 +: AW] = 19'h00100;
      din_s[d][0 +: DW] = 8'h3C;
      req_s[d][0] = 1'b1;
    end
    for (int r = 1; r <= 6; r++) begin
      step();
      for (int d = 0; d < 2; d++) begin
        if (r <= 5) chk("wr_oe", oe_s[d], (r <= 4));
        if (r <= 5) chk("wr_we_n", we_n_s[d], !(r == 2 || r == 3));
        if (r == 1) chk("wr_sram_dout", sram_dout_s[d], 8'h3C);
        if (r == 4) chk("wr_ack", ack_s[d], 3'b001);
      end
    end
    for (int d = 0; d < 2; d++) chk("wr_mem", prd(d, 19'h00100), 8'h3C);

    // Priority: all three channels held
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    ackq0.delete(); ackq1.delete(); ackc0.delete();
    for (int d = 0; d < 2; d++) begin
      we_s[d] = '0;
      addr_s[d] = {19'h00002, 19'h00001, 19'h00000};
      keep[d] = 3'b111;
      req_s[d] = 3'b111;
    end
    for (int r = 1; r <= 20; r++) step();
    chk("fp_count", ackq0.size(), 4);
    for (int i = 0; i < 4; i++) chk("fp_order", ackq0[i], 0);
    chk("fp_period", ackc0[1] - ackc0[0], WC + 3);
    chk("rr_count", ackq1.size(), 4);
    for (int i = 0; i < 4; i++) chk("rr_order", ackq1[i], i % 3);
    keep[1][1] = 1'b0;
    for (int r = 21; r <= 40; r++) step();
    chk("rr_skip_count", ackq1.size(), 8);
    chk("rr_skip4", ackq1[4], 1);
    chk("rr_skip5", ackq1[5], 2);
    chk("rr_skip6", ackq1[6], 0);
    chk("rr_skip7", ackq1[7], 2);
    for (int d = 0; d < 2; d++) begin req_s[d] = '0; keep[d] = '0; end
    for (int r = 0; r < 8; r++) step();

    // Reset during the strobe of a write
    for (int d = 0; d < 2; d++) begin
      we_s[d][0] = 1'b1;
      addr_s[d][0 +: AW] = 19'h00100;
      din_s[d][0 +: DW] = 8'h77;
      req_s[d][0] = 1'b1;
    end
    step(); step();
    for (int d = 0; d < 2; d++) chk("mid_we_n_low", we_n_s[d], 1'b0);
    #2 rst = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("mid_rst_we_n", we_n_s[d], 1'b1);
      chk("mid_rst_ack", ack_s[d], 3'b000);
      chk("mid_rst_busy", busy_s[d], 1'b0);
      chk("mid_rst_oe", oe_s[d], 1'b0);
      chk("mid_rst_addr", sram_addr_s[d], 19'h0);
      chk("mid_rst_dout", dout_s[d], 8'h00);
      req_s[d] = '0;
    end
    step(); step();
    rst = 1'b0;
    for (int d = 0; d < 2; d++) begin
      we_s[d][0] = 1'b0;
      req_s[d][0] = 1'b1;
    end
    for (int r = 1; r <= 6; r++) begin
      step();
      for (int d = 0; d < 2; d++) begin
        if (r == 4) chk("rd_after_rst_ack", ack_s[d], 3'b001);
        if (r >= 4) chk("rd_after_rst_dout", dout_s[d], 8'h3C);
      end
    end

    // Random traffic
    rand_en = 1'b1;
    for (int r = 0; r < 400; r++) step();
    rand_en = 1'b0;
    for (int d = 0; d < 2; d++) keep[d] = '0;
    for (int r = 0; r < 40; r++) step();
    for (int d = 0; d < 2; d++) chk("drain_busy", busy_s[d], 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Parametrised multi-channel arbiter and timing generator for the board's single-port asynchronous 8-bit SRAM. It sits between the machine core and the top-level SRAM pins. It replaces the single-master direct connection with NCH requesters, selectable fixed or round-robin priority, and programmable access length. The top level owns the tristate buffer, driving `sram_data` from `sram_dout` when `sram_oe` is high.

## Interface
- `NCH`, 2, number of requesting channels, legal range 1..8.
- `AW`, 19, SRAM address width.
- `DW`, 8, SRAM data width.
- `WAIT_CYCLES`, 2, clock cycles the strobe phase lasts; must be ≥1.
- `RR`, 0, priority mode: 0 = fixed (channel 0 highest), 1 = round-robin.

Ports:
- `clk` in 1: system clock (28 MHz domain).
- `rst` in 1: asynchronous, active-high reset.
- `req` in NCH: per-channel request level; held high until that channel's `ack`.
- `we` in NCH: per-channel write flag, 1 = write; valid while `req` is high.
- `addr` in NCH*AW: flattened addresses, channel i at bits [i*AW +: AW].
- `din` in NCH*DW: flattened write data, same packing as `addr`.
- `ack` out NCH: one-cycle completion pulse for the granted channel.
- `dout` out DW: read data, valid from the `ack` cycle until the next read completes.
- `busy` out 1: high in every state except IDLE.
- `sram_addr` out AW: SRAM address.
- `sram_dout` out DW: data to the SRAM.
- `sram_oe` out 1: top level drives `sram_data` when high.
- `sram_din` in DW: value read from the `sram_data` pin.
- `sram_we_n` out 1: SRAM write strobe, active low.

## Operation
- FSM states: IDLE → SETUP → ACTIVE → HOLD → IDLE.
- IDLE:
  - If any `req` bit is high, choose grant g and latch `addr[g]`, `din[g]` and `we[g]` into registers, then go to SETUP.
  - If no `req` bit is high, stay in IDLE.
- Grant selection:
  - RR=0: lowest-index active request.
  - RR=1: first active request searching upward from `last+1` modulo NCH. `last` updates to g on grant.
- SETUP (1 cycle):
  - `sram_addr` = latched address.
  - `sram_oe` = latched write flag.
  - `sram_we_n` = 1.
  - Counter loads WAIT_CYCLES-1.
- ACTIVE (WAIT_CYCLES cycles):
  - `sram_we_n` = 0 if write, 1 if read.
  - Counter decrements each cycle; at 0, go to HOLD.
  - Read: `dout` captures `sram_din` on the clock edge that leaves ACTIVE.
- HOLD (1 cycle):
  - `sram_we_n` = 1.
  - `sram_oe` stays high for a write, so data hold covers the rising edge of `sram_we_n`.
  - `ack[g]` = 1.
  - Next state is IDLE unconditionally.
- Address and data outputs are registered. They change only on the transition out of IDLE, so they are stable through SETUP, ACTIVE and HOLD.
- Grant changes only in IDLE. A request arriving mid-access waits.
- If a requester keeps `req` high after `ack`, it issues a new access. It is arbitrated normally in the following IDLE cycle.
- A `req` that drops before `ack` is a protocol violation. The access already started still completes and pulses `ack`.
- NCH=1 degenerates to a single-master timing generator; RR has no effect.

## Timing
- Reset values: state IDLE, `sram_we_n`=1, `sram_oe`=0, `sram_addr`=0, `sram_dout`=0, `ack`=0, `dout`=0, `busy`=0, `last`=NCH-1 (so channel 0 wins the first round-robin grant).
- Latency: request sampled in IDLE at cycle 0 → `ack` high in cycle WAIT_CYCLES+2.
- Throughput: one access per WAIT_CYCLES+3 cycles with continuous requests.
- Write strobe: `sram_we_n` low for exactly WAIT_CYCLES cycles, with one cycle of address/data setup before it and one cycle of hold after it.
- Reset mid-access:
  - All outputs return to reset values asynchronously, the same instant `rst` rises.
  - `sram_we_n` goes high immediately; the write is lost.
  - No `ack` is issued; requesters must re-request.
- Simultaneous requests are resolved only in IDLE, within a single cycle.

## Test plan
- Reset: hold `rst`=1 with random inputs → `sram_we_n`=1, `sram_oe`=0, `ack`=0, `busy`=0.
- Single read, WAIT_CYCLES=2: ch1 reads 0x12345; SRAM model returns 0xA5 → `sram_addr`=0x12345 from cycle 1 to cycle 4; `ack`=2'b10 in cycle 4; `dout`=0xA5; `sram_we_n` never low.
- Single write: ch0 writes 0x3C to 0x00100 → `sram_oe` high in cycles 1–4; `sram_dout`=0x3C; `sram_we_n` low only in cycles 2–3; model memory holds 0x3C afterwards.
- Fixed priority, NCH=3: `req`=3'b111 held throughout → grant order 0,0,0… (ch0 starves the others), one `ack` every 5 cycles.
- Round-robin, NCH=3, RR=1: `req`=3'b111 held → `ack` order ch0, ch1, ch2, ch0; each requester dropping its `req` on `ack` is skipped in the rotation.
- Reset during ACTIVE of a write: `sram_we_n` rises in the same instant as `rst`, no `ack` pulses; after release, a new read of the same address returns the old value.
